// File: rtl/const_load_seq.sv
// Multi-cycle immediate loader: sequences LUI, OR and a register-file write through the shared ALU.
// Optional CONST_LOAD_SKIP_OR_EN skips the OR step when the low half of the immediate is zero.
module const_load_seq #(
    parameter int unsigned N      = 32,
    parameter int unsigned RW     = 5,
    parameter logic [3:0]  OP_LUI = 4'd9,
    parameter logic [3:0]  OP_OR  = 4'd3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [N-1:0]  req_imm,
    input  logic [RW-1:0] req_rd,
    output logic [3:0]    alu_op,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    input  logic [N-1:0]  alu_res,
    output logic          rf_we,
    output logic [RW-1:0] rf_waddr,
    output logic [N-1:0]  rf_wdata,
    output logic          busy,
    output logic          done
);

    localparam int unsigned H = N / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        S_LUI = 2'd1,
        S_OR  = 2'd2,
        S_WB  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [H-1:0]  imm_lo_q, imm_lo_d;
    logic [RW-1:0] rd_q, rd_d;

    logic          req_ready_d, busy_d, done_d, rf_we_d;
    logic [3:0]    alu_op_d;
    logic [N-1:0]  alu_a_d, alu_b_d, rf_wdata_d;
    logic [RW-1:0] rf_waddr_d;
    logic          skip_or;

    // The ALU result captured in S_LUI is already final when the low half is zero.
`ifdef CONST_LOAD_SKIP_OR_EN
    assign skip_or = (imm_lo_q == '0);
`else
    assign skip_or = 1'b0;
`endif

    // Next state plus the output values that belong to that next state, so every output is a flop.
    // The upper immediate half is consumed at accept time, so only the lower half is kept.
    always_comb begin
        state_d     = state_q;
        imm_lo_d    = imm_lo_q;
        rd_d        = rd_q;
        req_ready_d = 1'b0;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        alu_op_d    = '0;
        alu_a_d     = '0;
        alu_b_d     = '0;
        rf_we_d     = 1'b0;
        rf_waddr_d  = '0;
        rf_wdata_d  = '0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d  = S_LUI;
                    imm_lo_d = req_imm[H-1:0];
                    rd_d     = req_rd;
                    alu_op_d = OP_LUI;
                    alu_a_d  = {{H{1'b0}}, req_imm[N-1:H]};
                end else begin
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            S_LUI: begin
                if (skip_or) begin
                    state_d    = S_WB;
                    rf_we_d    = (rd_q != '0);
                    rf_waddr_d = rd_q;
                    rf_wdata_d = alu_res;
                    done_d     = 1'b1;
                end else begin
                    state_d  = S_OR;
                    alu_op_d = OP_OR;
                    alu_a_d  = alu_res;
                    alu_b_d  = {{H{1'b0}}, imm_lo_q};
                end
            end
            S_OR: begin
                state_d    = S_WB;
                rf_we_d    = (rd_q != '0);
                rf_waddr_d = rd_q;
                rf_wdata_d = alu_res;
                done_d     = 1'b1;
            end
            S_WB: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            imm_lo_q  <= '0;
            rd_q      <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            state_q   <= state_d;
            imm_lo_q  <= imm_lo_d;
            rd_q      <= rd_d;
            req_ready <= req_ready_d;
            busy      <= busy_d;
            done      <= done_d;
            alu_op    <= alu_op_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            rf_we     <= rf_we_d;
            rf_waddr  <= rf_waddr_d;
            rf_wdata  <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_const_load_seq.sv
// Bench for const_load_seq: transaction-level model with per-cycle compare, directed cases and random traffic.
`timescale 1ns/1ps
module tb_const_load_seq;

    localparam int unsigned N  = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned H  = N / 2;
    localparam logic [3:0] OP_LUI = 4'd9;
    localparam logic [3:0] OP_OR  = 4'd3;
`ifdef CONST_LOAD_SKIP_OR_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, rf_we, busy, done;
    logic [N-1:0]  req_imm, alu_a, alu_b, alu_res, rf_wdata;
    logic [RW-1:0] req_rd, rf_waddr;
    logic [3:0]    alu_op;

    const_load_seq #(.N(N), .RW(RW), .OP_LUI(OP_LUI), .OP_OR(OP_OR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_imm(req_imm), .req_rd(req_rd),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .done(done)
    );

    // Narrow instance for the N=8 sweep.
    logic       v8, rdy8, we8, busy8, done8;
    logic [7:0] imm8, a8, b8, res8, wdata8;
    logic [2:0] rd8, waddr8;
    logic [3:0] op8;

    const_load_seq #(.N(8), .RW(3), .OP_LUI(OP_LUI), .OP_OR(OP_OR)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v8), .req_ready(rdy8), .req_imm(imm8), .req_rd(rd8),
        .alu_op(op8), .alu_a(a8), .alu_b(b8), .alu_res(res8),
        .rf_we(we8), .rf_waddr(waddr8), .rf_wdata(wdata8),
        .busy(busy8), .done(done8)
    );

    // External ALU behaviour.
    always_comb begin
        case (alu_op)
            OP_LUI:  alu_res = {alu_a[H-1:0], {H{1'b0}}};
            OP_OR:   alu_res = alu_a | alu_b;
            default: alu_res = '0;
        endcase
        case (op8)
            OP_LUI:  res8 = {a8[3:0], 4'h0};
            OP_OR:   res8 = a8 | b8;
            default: res8 = '0;
        endcase
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'(1));
        chk({tag, "_busy"},  64'(busy),      64'(0));
        chk({tag, "_done"},  64'(done),      64'(0));
        chk({tag, "_we"},    64'(rf_we),     64'(0));
        chk({tag, "_op"},    64'(alu_op),    64'(0));
        chk({tag, "_a"},     64'(alu_a),     64'(0));
        chk({tag, "_b"},     64'(alu_b),     64'(0));
        chk({tag, "_waddr"}, 64'(rf_waddr),  64'(0));
        chk({tag, "_wdata"}, 64'(rf_wdata),  64'(0));
    endtask

    // Transaction model: one outstanding load, step number since acceptance and its total length.
    bit            m_act;
    int            m_phase, m_len;
    logic [N-1:0]  m_imm;
    logic [RW-1:0] m_rd;

    function automatic int len_for(input logic [N-1:0] imm);
        return (SKIP_EN && (imm % (64'd1 << H)) == 0) ? 2 : 3;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act   <= 1'b0;
            m_phase <= 0;
        end else if (!m_act) begin
            if (req_valid) begin
                m_act   <= 1'b1;
                m_phase <= 1;
                m_len   <= len_for(req_imm);
                m_imm   <= req_imm;
                m_rd    <= req_rd;
            end
        end else if (m_phase == m_len) begin
            m_act <= 1'b0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    bit            cmp_en = 1'b0;
    logic          e_ready, e_busy, e_we, e_done;
    logic [3:0]    e_op;
    logic [N-1:0]  e_a, e_b, e_wdata;
    logic [RW-1:0] e_waddr;

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            e_ready = !m_act; e_busy = m_act; e_we = 1'b0; e_done = 1'b0;
            e_op = '0; e_a = '0; e_b = '0; e_wdata = '0; e_waddr = '0;
            if (m_act) begin
                if (m_phase == 1) begin
                    e_op = OP_LUI;
                    e_a  = m_imm >> H;
                end else if (m_phase == 2 && m_len == 3) begin
                    e_op = OP_OR;
                    e_a  = (m_imm >> H) << H;
                    e_b  = m_imm ^ e_a;
                end
                if (m_phase == m_len) begin
                    e_we    = (m_rd != 0);
                    e_waddr = m_rd;
                    e_wdata = m_imm;
                    e_done  = 1'b1;
                end
            end
            chk("cyc_ready", 64'(req_ready), 64'(e_ready));
            chk("cyc_busy",  64'(busy),      64'(e_busy));
            chk("cyc_done",  64'(done),      64'(e_done));
            chk("cyc_we",    64'(rf_we),     64'(e_we));
            chk("cyc_op",    64'(alu_op),    64'(e_op));
            chk("cyc_a",     64'(alu_a),     64'(e_a));
            chk("cyc_b",     64'(alu_b),     64'(e_b));
            chk("cyc_waddr", 64'(rf_waddr),  64'(e_waddr));
            chk("cyc_wdata", 64'(rf_wdata),  64'(e_wdata));
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) sync();
    endtask

    // Presents a request to an idle DUT; returns 1ns after the accept edge.
    task automatic send(input logic [N-1:0] imm, input logic [RW-1:0] rd);
        req_valid = 1'b1;
        req_imm   = imm;
        req_rd    = rd;
        sync();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0; req_imm = '0; req_rd = '0;
        v8 = 1'b0; imm8 = '0; rd8 = '0;
        repeat (2) @(posedge clk);
        #1 chk_reset("rst");
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;
        sync();

        // Basic load
        idle(2);
        send(32'hDEAD_BEEF, 5'd5);
        @(negedge clk);
        chk("basic_lui_op", 64'(alu_op), 64'(OP_LUI));
        chk("basic_lui_a", 64'(alu_a), 64'(32'h0000_DEAD));
        chk("basic_lui_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        chk("basic_or_a", 64'(alu_a), 64'(32'hDEAD_0000));
        chk("basic_or_b", 64'(alu_b), 64'(32'h0000_BEEF));
        @(negedge clk);
        chk("basic_wb_we", 64'(rf_we), 64'(1));
        chk("basic_wb_waddr", 64'(rf_waddr), 64'(5));
        chk("basic_wb_wdata", 64'(rf_wdata), 64'(32'hDEAD_BEEF));
        chk("basic_wb_done", 64'(done), 64'(1));
        @(negedge clk);
        chk("basic_ready_back", 64'(req_ready), 64'(1));
        sync();

        // Low half zero
        send(32'h1234_0000, 5'd7);
        @(negedge clk);
        chk("skip_lui_op", 64'(alu_op), 64'(OP_LUI));
        @(negedge clk);
`ifdef CONST_LOAD_SKIP_OR_EN
        chk("skip_k2_we", 64'(rf_we), 64'(1));
        chk("skip_k2_op", 64'(alu_op), 64'(0));
        chk("skip_k2_wdata", 64'(rf_wdata), 64'(32'h1234_0000));
`else
        chk("skip_k2_op", 64'(alu_op), 64'(OP_OR));
        chk("skip_k2_done", 64'(done), 64'(0));
        @(negedge clk);
        chk("skip_k3_we", 64'(rf_we), 64'(1));
        chk("skip_k3_wdata", 64'(rf_wdata), 64'(32'h1234_0000));
`endif
        idle(3);

        // Destination r0
        send(32'hFFFF_FFFF, 5'd0);
        repeat (3) @(negedge clk);
        chk("r0_done", 64'(done), 64'(1));
        chk("r0_we", 64'(rf_we), 64'(0));
        idle(2);

        // Back-to-back with request changing while busy
        req_valid = 1'b1; req_imm = 32'h0F0F_1234; req_rd = 5'd9;
        sync();
        req_imm = 32'h5555_AAAA; req_rd = 5'd12;
        @(negedge clk) chk("b2b_k1_ready", 64'(req_ready), 64'(0));
        @(negedge clk) chk("b2b_k2_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        chk("b2b_k3_ready", 64'(req_ready), 64'(0));
        chk("b2b_k3_wdata", 64'(rf_wdata), 64'(32'h0F0F_1234));
        chk("b2b_k3_waddr", 64'(rf_waddr), 64'(9));
        @(negedge clk) chk("b2b_k4_ready", 64'(req_ready), 64'(1));
        sync();
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_op", 64'(alu_op), 64'(OP_LUI));
        chk("b2b_second_a", 64'(alu_a), 64'(32'h0000_5555));
        idle(4);

        // Reset during S_OR
        send(32'hCAFE_F00D, 5'd4);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("midrst");
        #1 rst_n = 1'b1;
        sync();
        send(32'h0000_0001, 5'd3);
        repeat (3) @(negedge clk);
        chk("after_rst_we", 64'(rf_we), 64'(1));
        chk("after_rst_waddr", 64'(rf_waddr), 64'(3));
        chk("after_rst_wdata", 64'(rf_wdata), 64'(32'h0000_0001));
        idle(2);

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_imm   = $urandom;
            if ($urandom_range(0, 3) == 0) req_imm[H-1:0] = '0;
            req_rd    = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom);
            if ($urandom_range(0, 60) == 0) begin
                #1 rst_n = 1'b0;
                #1 chk_reset("rnd_rst");
                #1 rst_n = 1'b1;
            end
            sync();
        end
        idle(4);

        // N=8 sweep
        v8 = 1'b1; imm8 = 8'hA5; rd8 = 3'd2;
        sync();
        v8 = 1'b0;
        @(negedge clk);
        chk("n8_lui_op", 64'(op8), 64'(OP_LUI));
        chk("n8_lui_a", 64'(a8), 64'(8'h0A));
        @(negedge clk);
        chk("n8_or_a", 64'(a8), 64'(8'hA0));
        chk("n8_or_b", 64'(b8), 64'(8'h05));
        @(negedge clk);
        chk("n8_wdata", 64'(wdata8), 64'(8'hA5));
        chk("n8_we", 64'(we8), 64'(1));
        chk("n8_done", 64'(done8), 64'(1));
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/const_load_seq.md
# const_load_seq

Multi-cycle controller that loads a full N-bit immediate into a register by sequencing the shared ALU. It issues an upper-half load-immediate (LUI) operation, then an OR of the lower half, then a register-file write. It sits between decode and the ALU/register file, and owns the ALU and write port only while busy. Requests use a valid/ready handshake; completion is signalled with a one-cycle `done` pulse.

## Interface
Parameters:
- `N`, 32, data width; must be even and ≥ 4.
- `RW`, 5, register address width.
- `OP_LUI`, 4'd9, ALU opcode for LUI; the ALU places `a[N/2-1:0]` in `res[N-1:N/2]` and zeros the low half.
- `OP_OR`, 4'd3, ALU opcode for bitwise OR.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_imm`  in  N  immediate to load.
- `req_rd`  in  RW  destination register.
- `alu_op`  out  4  ALU opcode.
- `alu_a`  out  N  ALU operand A.
- `alu_b`  out  N  ALU operand B.
- `alu_res`  in  N  ALU result, combinational in the same cycle.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  RW  write address.
- `rf_wdata`  out  N  write data.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in the write-back cycle.

## Operation
States: IDLE, S_LUI, S_OR, S_WB.

- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`: latch `imm_q`←`req_imm` and `rd_q`←`req_rd`, then go to S_LUI.
- **S_LUI**
  - Drives `alu_op`=`OP_LUI`, `alu_a`={N/2'b0, `imm_q[N-1:N/2]`}, `alu_b`=0.
  - At the clock edge: `tmp_q`←`alu_res`, then go to S_OR.
- **S_OR**
  - Drives `alu_op`=`OP_OR`, `alu_a`=`tmp_q`, `alu_b`={N/2'b0, `imm_q[N/2-1:0]`}.
  - At the clock edge: `tmp_q`←`alu_res`, then go to S_WB.
- **S_WB**
  - Drives `rf_we`=1, `rf_waddr`=`rd_q`, `rf_wdata`=`tmp_q`, `done`=1, then go to IDLE.
- **Destination r0**: when `rd_q`==0, `rf_we` stays 0 in S_WB. The sequence still runs and `done` still pulses.
- **Idle drive values**: outside S_LUI and S_OR, `alu_op`, `alu_a` and `alu_b` are driven to 0. Outside S_WB, `rf_we`=0 and `rf_waddr`/`rf_wdata` are 0.
- **Request hold rule**: `req_imm` and `req_rd` are sampled only at the accept edge. Changes to them while busy are ignored.
- **No pipelining**: `req_ready` is low in S_LUI, S_OR and S_WB. A request presented during S_WB is accepted only from the following IDLE cycle.

## Timing
- **Reset values**: state=IDLE, `imm_q`/`rd_q`/`tmp_q`=0, `req_ready`=1, `busy`=0, `done`=0, `rf_we`=0, all data outputs 0.
- **Reset mid-operation**: asserting `rst_n` low in any state returns to IDLE immediately (asynchronous). No write occurs and no `done` pulse is produced.
- **Latency**: with accept at edge k, S_LUI is cycle k+1, S_OR is k+2, S_WB (`rf_we`, `done`) is k+3, and IDLE/`req_ready` returns at k+4.
- **Throughput**: one load per 4 cycles.
- **Combinational paths**: the ALU path is combinational through the external ALU. All controller outputs are decoded from registered state and registered data only. There is no combinational path from `req_*` to any output except through the state register.

## Configuration
- **`CONST_LOAD_SKIP_OR_EN`**
  - Defined: if `imm_q[N/2-1:0]`==0 at the end of S_LUI, the FSM goes S_LUI→S_WB and S_OR is skipped. Write-back then occurs at k+2 and `req_ready` returns at k+3.
  - Undefined: S_OR always executes; the result is identical, but latency is fixed at 3.

## Test plan
- **Basic load**: reset, then request imm=32'hDEAD_BEEF, rd=5.
  - S_LUI shows `alu_a`=32'h0000_DEAD with `OP_LUI`.
  - S_OR shows `alu_a`=32'hDEAD_0000 and `alu_b`=32'h0000_BEEF.
  - At k+3: `rf_we`=1, `rf_waddr`=5, `rf_wdata`=32'hDEAD_BEEF, `done`=1.
- **Skip path**: imm=32'h1234_0000, rd=7.
  - Macro undefined: write at k+3.
  - Macro defined: write at k+2, no `OP_OR` cycle, `rf_wdata`=32'h1234_0000.
- **Register zero**: imm=32'hFFFF_FFFF, rd=0.
  - `done` pulses at k+3 with `rf_we`=0 throughout.
- **Back-to-back**: hold `req_valid`=1 with two different requests.
  - Second request accepted exactly at k+4, and `req_ready`=0 during k+1..k+3.
  - Changing `req_imm` while busy does not alter the first result.
- **Reset mid-operation**: assert `rst_n`=0 during S_OR.
  - All outputs return to reset values immediately.
  - No `rf_we` or `done` is produced.
  - After release, a new request imm=32'h0000_0001, rd=3 completes correctly.
- **Parameter sweep**: N=8, imm=8'hA5.
  - S_LUI `alu_a`=8'h0A, final `rf_wdata`=8'hA5.
